// File: rtl/servo_scan_sequencer.sv
// APB-programmable two-axis servo raster scanner: steps X (fast) then Y across a
// window, holding each point for a settle frame plus DWELL frames of the PWM period.
module servo_scan_sequencer #(
    parameter int unsigned PWM_PERIOD = 2000000,
    parameter int unsigned PW_MIN     = 100000,
    parameter int unsigned PW_MAX     = 200000,
    parameter int unsigned PW_NEUTRAL = 150000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [1:0]  stop_x,
    input  logic [1:0]  stop_y,
    output logic [31:0] x_pw,
    output logic [31:0] y_pw,
    output logic        x_pw_load,
    output logic        y_pw_load,
    output logic        busy,
    output logic        done_pulse
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        DWELL  = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(PWM_PERIOD - 1);
    localparam logic [31:0]   PW_MIN_L   = 32'(PW_MIN);
    localparam logic [31:0]   PW_MAX_L   = 32'(PW_MAX);
    localparam logic [31:0]   PW_NEUT_L  = 32'(PW_NEUTRAL);

    state_t        state_q, state_d;
    logic [CW-1:0] frame_q, frame_d;
    logic [31:0]   xPw_q, xPw_d, yPw_q, yPw_d;
    logic          xLoad_q, xLoad_d, yLoad_q, yLoad_d;
    logic          done_q, done_d, fault_q, fault_d;
    logic [7:0]    dwellCnt_q, dwellCnt_d;

    logic [31:0] xStart_q, xEnd_q, yStart_q, yEnd_q, step_q;
    logic [7:0]  dwell_q;
    logic [31:0] prdata_q, rdMux;

    logic [12:0] addr;
    logic        wrEn, rdEn, ctrlWr, startReq, abortReq;
    logic        busyNow, limitHit, frameTick, startBad;
    logic [32:0] xSum, ySum;
    logic        unused_addr;

    function automatic logic [31:0] clampPw(input logic [31:0] v);
        if (v < PW_MIN_L)      return PW_MIN_L;
        else if (v > PW_MAX_L) return PW_MAX_L;
        else                   return v;
    endfunction

    assign addr        = PADDR[12:0];
    assign unused_addr = ^PADDR[31:13];
    assign wrEn        = PSEL & PWRITE & PENABLE;
    assign rdEn        = PSEL & ~PWRITE;
    assign ctrlWr      = wrEn && (addr == 13'h200);
    assign startReq    = ctrlWr & PWDATA[0];
    assign abortReq    = ctrlWr & PWDATA[1];
    assign busyNow     = (state_q == SETTLE) || (state_q == DWELL);
    assign limitHit    = ~&{stop_x, stop_y};
    assign frameTick   = (frame_q == FRAME_LAST);
    assign startBad    = (step_q == 32'd0) || (xStart_q > xEnd_q) || (yStart_q > yEnd_q);
    // 33-bit sums so a wrap past 2^32 compares as exceeding the end point
    assign xSum        = {1'b0, xPw_q} + {1'b0, step_q};
    assign ySum        = {1'b0, yPw_q} + {1'b0, step_q};

    always_comb begin
        state_d    = state_q;
        frame_d    = frameTick ? '0 : frame_q + 1'b1;
        xPw_d      = xPw_q;
        yPw_d      = yPw_q;
        xLoad_d    = 1'b0;
        yLoad_d    = 1'b0;
        done_d     = 1'b0;
        fault_d    = fault_q;
        dwellCnt_d = dwellCnt_q;
        if (busyNow && limitHit) begin
            state_d = FAULT;
            xPw_d   = PW_NEUT_L;
            yPw_d   = PW_NEUT_L;
            xLoad_d = 1'b1;
            yLoad_d = 1'b1;
            done_d  = 1'b1;
            fault_d = 1'b1;
        end else if (busyNow && abortReq) begin
            state_d = IDLE;
            xPw_d   = PW_NEUT_L;
            yPw_d   = PW_NEUT_L;
            xLoad_d = 1'b1;
            yLoad_d = 1'b1;
        end else if (!busyNow && startReq) begin
            if (startBad) begin
                state_d = FAULT;
                done_d  = 1'b1;
                fault_d = 1'b1;
            end else begin
                state_d = SETTLE;
                xPw_d   = xStart_q;
                yPw_d   = yStart_q;
                xLoad_d = 1'b1;
                yLoad_d = 1'b1;
                fault_d = 1'b0;
            end
        end else if (frameTick) begin
            case (state_q)
                SETTLE: begin
                    dwellCnt_d = (dwell_q == 8'd0) ? 8'd1 : dwell_q;
                    state_d    = DWELL;
                end
                DWELL: begin
                    if (dwellCnt_q == 8'd1) begin
                        state_d = SETTLE;
                        if (xSum <= {1'b0, xEnd_q}) begin
                            xPw_d   = xSum[31:0];
                            xLoad_d = 1'b1;
                        end else if (ySum <= {1'b0, yEnd_q}) begin
                            xPw_d   = xStart_q;
                            yPw_d   = ySum[31:0];
                            xLoad_d = 1'b1;
                            yLoad_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            xPw_d   = PW_NEUT_L;
                            yPw_d   = PW_NEUT_L;
                            xLoad_d = 1'b1;
                            yLoad_d = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        dwellCnt_d = dwellCnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            xPw_q      <= PW_NEUT_L;
            yPw_q      <= PW_NEUT_L;
            xLoad_q    <= 1'b0;
            yLoad_q    <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            dwellCnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            xPw_q      <= xPw_d;
            yPw_q      <= yPw_d;
            xLoad_q    <= xLoad_d;
            yLoad_q    <= yLoad_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            dwellCnt_q <= dwellCnt_d;
        end
    end

    always_comb begin
        rdMux = 32'hFFFF_FFFF;
        case (addr)
            13'h200: rdMux = 32'd0;
            13'h204: rdMux = xStart_q;
            13'h208: rdMux = xEnd_q;
            13'h20C: rdMux = yStart_q;
            13'h210: rdMux = yEnd_q;
            13'h214: rdMux = step_q;
            13'h218: rdMux = {24'd0, dwell_q};
            13'h21C: rdMux = {27'd0, fault_q, busyNow, state_q};
            13'h220: rdMux = xPw_q;
            13'h224: rdMux = yPw_q;
            default: ;
        endcase
    end

    // Scan window is frozen while a scan runs so the raster cannot tear mid-pass
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            xStart_q <= PW_NEUT_L;
            xEnd_q   <= PW_NEUT_L;
            yStart_q <= PW_NEUT_L;
            yEnd_q   <= PW_NEUT_L;
            step_q   <= 32'd0;
            dwell_q  <= 8'd1;
            prdata_q <= 32'hFFFF_FFFF;
        end else begin
            if (wrEn && !busyNow) begin
                case (addr)
                    13'h204: xStart_q <= clampPw(PWDATA);
                    13'h208: xEnd_q   <= clampPw(PWDATA);
                    13'h20C: yStart_q <= clampPw(PWDATA);
                    13'h210: yEnd_q   <= clampPw(PWDATA);
                    13'h214: step_q   <= PWDATA;
                    13'h218: dwell_q  <= PWDATA[7:0];
                    default: ;
                endcase
            end
            if (rdEn) prdata_q <= rdMux;
        end
    end

    assign PRDATA     = prdata_q;
    assign PREADY     = 1'b1;
    assign PSLVERR    = 1'b0;
    assign x_pw       = xPw_q;
    assign y_pw       = yPw_q;
    assign x_pw_load  = xLoad_q;
    assign y_pw_load  = yLoad_q;
    assign busy       = busyNow;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_servo_scan_sequencer.sv
// Directed bench for servo_scan_sequencer with a 100-cycle frame: reset values,
// clamping, full raster scan, invalid start, limit fault, abort and mid-scan reset.
module tb_servo_scan_sequencer;

    logic        clk = 1'b0;
    logic        PRESERN, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [1:0]  stop_x, stop_y;
    logic [31:0] x_pw, y_pw;
    logic        x_pw_load, y_pw_load, busy, done_pulse;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;
    int cycle = 0;
    int doneCount = 0;
    logic [31:0] xLog[$];
    logic [31:0] yLog[$];
    int          xTimes[$];
    logic [31:0] rd;

    localparam logic [31:0] A_CTRL = 32'h200, A_XS = 32'h204, A_XE = 32'h208;
    localparam logic [31:0] A_YS = 32'h20C, A_YE = 32'h210, A_STEP = 32'h214;
    localparam logic [31:0] A_DWELL = 32'h218, A_STAT = 32'h21C;

    servo_scan_sequencer #(.PWM_PERIOD(100)) dut (
        .PCLK(clk), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .stop_x(stop_x), .stop_y(stop_y), .x_pw(x_pw), .y_pw(y_pw),
        .x_pw_load(x_pw_load), .y_pw_load(y_pw_load), .busy(busy), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Strobe monitor samples a few ns after the edge, never racing the stimulus at negedge
    always @(posedge clk) begin
        #3;
        if (x_pw_load) begin
            xLog.push_back(x_pw);
            xTimes.push_back(cycle);
        end
        if (y_pw_load) yLog.push_back(y_pw);
        if (done_pulse) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apbRead(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        data = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic clearLogs();
        xLog.delete();
        yLog.delete();
        xTimes.delete();
        doneCount = 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] expX[7];
        logic [31:0] expY[3];
        logic seen;
        int   polls;
        expX = '{32'd100000, 32'd100010, 32'd100020, 32'd100000, 32'd100010, 32'd100020, 32'd150000};
        expY = '{32'd150000, 32'd150010, 32'd150000};

        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; stop_x = 2'b11; stop_y = 2'b11;
        repeat (2) @(negedge clk);

        checkOutput("rst_x_pw", x_pw, 32'd150000);
        checkOutput("rst_y_pw", y_pw, 32'd150000);
        checkOutput("rst_loads", {30'd0, x_pw_load, y_pw_load}, 32'd0);
        checkOutput("rst_busy_done", {30'd0, busy, done_pulse}, 32'd0);
        checkOutput("rst_prdata", PRDATA, 32'hFFFF_FFFF);
        PRESERN = 1'b1;
        apbRead(A_STAT, rd);   checkOutput("rst_status", rd, 32'd0);
        apbRead(A_XS, rd);     checkOutput("rst_xstart", rd, 32'd150000);
        apbRead(A_STEP, rd);   checkOutput("rst_step", rd, 32'd0);
        apbRead(A_DWELL, rd);  checkOutput("rst_dwell", rd, 32'd1);
        apbRead(32'h300, rd);  checkOutput("unmapped_read", rd, 32'hFFFF_FFFF);

        // Clamping on store
        applyStimulus(A_XS, 32'd50000);
        apbRead(A_XS, rd);     checkOutput("clamp_low", rd, 32'd100000);
        applyStimulus(A_XE, 32'd250000);
        apbRead(A_XE, rd);     checkOutput("clamp_high", rd, 32'd200000);

        // Full 3x2 raster scan
        applyStimulus(A_XS, 32'd100000);
        applyStimulus(A_XE, 32'd100020);
        applyStimulus(A_YS, 32'd150000);
        applyStimulus(A_YE, 32'd150010);
        applyStimulus(A_STEP, 32'd10);
        applyStimulus(A_DWELL, 32'd2);
        clearLogs();
        applyStimulus(A_CTRL, 32'd1);
        checkOutput("scan_start_x", x_pw, 32'd100000);
        checkOutput("scan_start_loads", {30'd0, x_pw_load, y_pw_load}, 32'd3);
        checkOutput("scan_busy", {31'd0, busy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 2500 && !seen; i++) begin
            @(negedge clk);
            if (done_pulse) seen = 1'b1;
        end
        checkOutput("scan_done_seen", {31'd0, seen}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("scan_x_count", xLog.size(), 32'd7);
        checkOutput("scan_y_count", yLog.size(), 32'd3);
        for (int i = 0; i < 7; i++)
            checkOutput($sformatf("scan_x%0d", i), (i < xLog.size()) ? xLog[i] : 32'hDEAD_BEEF, expX[i]);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("scan_y%0d", i), (i < yLog.size()) ? yLog[i] : 32'hDEAD_BEEF, expY[i]);
        checkOutput("scan_hold_a", (xTimes.size() > 2) ? 32'(xTimes[2] - xTimes[1]) : 32'd0, 32'd300);
        checkOutput("scan_hold_b", (xTimes.size() > 6) ? 32'(xTimes[6] - xTimes[5]) : 32'd0, 32'd300);
        checkOutput("scan_done_once", doneCount, 32'd1);
        apbRead(A_STAT, rd);   checkOutput("scan_status_done", rd, 32'd3);

        // STEP == 0 start faults without touching the servos
        applyStimulus(A_STEP, 32'd0);
        clearLogs();
        applyStimulus(A_CTRL, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("step0_loads", xLog.size() + yLog.size(), 32'd0);
        checkOutput("step0_done_once", doneCount, 32'd1);
        apbRead(A_STAT, rd);   checkOutput("step0_status", rd, 32'h14);

        // Lower Y limit switch trips during DWELL
        applyStimulus(A_STEP, 32'd10);
        applyStimulus(A_CTRL, 32'd1);
        apbRead(A_STAT, rd);   checkOutput("limit_fault_cleared", rd, 32'h9);
        polls = 0;
        while (rd[2:0] != 3'd2 && polls < 100) begin
            apbRead(A_STAT, rd);
            polls++;
        end
        checkOutput("limit_reached_dwell", {29'd0, rd[2:0]}, 32'd2);
        clearLogs();
        stop_y = 2'b10;
        @(negedge clk);
        checkOutput("limit_loads", {30'd0, x_pw_load, y_pw_load}, 32'd3);
        checkOutput("limit_x_pw", x_pw, 32'd150000);
        checkOutput("limit_y_pw", y_pw, 32'd150000);
        checkOutput("limit_busy", {31'd0, busy}, 32'd0);
        checkOutput("limit_done", {31'd0, done_pulse}, 32'd1);
        stop_y = 2'b11;
        apbRead(A_STAT, rd);   checkOutput("limit_status", rd, 32'h14);
        checkOutput("limit_x_count", xLog.size(), 32'd1);

        // Busy write ignored, then abort+start in one write
        applyStimulus(A_CTRL, 32'd1);
        applyStimulus(A_XS, 32'd120000);
        apbRead(A_XS, rd);     checkOutput("busy_write_ignored", rd, 32'd100000);
        clearLogs();
        applyStimulus(A_CTRL, 32'd3);
        checkOutput("abort_loads", {30'd0, x_pw_load, y_pw_load}, 32'd3);
        checkOutput("abort_x_pw", x_pw, 32'd150000);
        checkOutput("abort_busy_done", {30'd0, busy, done_pulse}, 32'd0);
        repeat (3) @(negedge clk);
        apbRead(A_STAT, rd);   checkOutput("abort_status", rd, 32'd0);
        checkOutput("abort_no_done", doneCount, 32'd0);
        checkOutput("abort_x_count", xLog.size(), 32'd1);

        // One-cycle reset in the middle of a scan
        applyStimulus(A_CTRL, 32'd1);
        repeat (50) @(negedge clk);
        clearLogs();
        PRESERN = 1'b0;
        @(negedge clk);
        PRESERN = 1'b1;
        checkOutput("mrst_x_pw", x_pw, 32'd150000);
        checkOutput("mrst_y_pw", y_pw, 32'd150000);
        checkOutput("mrst_strobes", {29'd0, x_pw_load, y_pw_load, done_pulse}, 32'd0);
        checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mrst_prdata", PRDATA, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        checkOutput("mrst_no_loads", xLog.size() + yLog.size() + doneCount, 32'd0);
        apbRead(A_XS, rd);     checkOutput("mrst_xstart", rd, 32'd150000);
        applyStimulus(A_XS, 32'd110000);
        applyStimulus(A_STEP, 32'd10);
        applyStimulus(A_CTRL, 32'd1);
        checkOutput("mrst_restart_x", x_pw, 32'd110000);
        checkOutput("mrst_restart_load", {31'd0, x_pw_load}, 32'd1);
        checkOutput("mrst_restart_busy", {31'd0, busy}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
